// File: rtl/sprite_linebuf_pp_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sprite_linebuf_pp_pkg
// Description : Shared constants and types for the ping-pong sprite line
//               buffer: default geometry, transparent pixel code and the
//               write-side FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package sprite_linebuf_pp_pkg;

  localparam int DEF_XW          = 8;  // line address width (256 pixels)
  localparam int DEF_PIXW        = 3;  // pixel value bits
  localparam int DEF_COLW        = 5;  // colour / palette bits
  localparam int PIX_TRANSPARENT = 0;  // pixel code never written to the RAM

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_RD   = 2'd1,
    W_WR   = 2'd2
  } lb_wstate_t;

endpackage
`default_nettype wire

// File: rtl/sprite_linebuf_pp_if.sv
`default_nettype none
// ============================================================================
// Interface   : sprite_linebuf_pp_if
// Description : Sprite pixel write channel (valid/ready handshake).
//   wr_valid  master->slave  pixel offered
//   wr_ready  slave->master  pixel accepted when wr_valid & wr_ready
//   wr_x      master->slave  target x (wraps modulo 2**XW)
//   wr_pix    master->slave  pixel value, 0 = transparent
//   wr_col    master->slave  colour stored with the pixel
// Revision    : 1.0 - initial release
// ============================================================================
interface sprite_linebuf_pp_if
  import sprite_linebuf_pp_pkg::*;
#(
  parameter int XW   = DEF_XW,
  parameter int PIXW = DEF_PIXW,
  parameter int COLW = DEF_COLW
);
  logic            wr_valid;
  logic            wr_ready;
  logic [XW-1:0]   wr_x;
  logic [PIXW-1:0] wr_pix;
  logic [COLW-1:0] wr_col;

  modport master (output wr_valid, wr_x, wr_pix, wr_col, input  wr_ready);
  modport slave  (input  wr_valid, wr_x, wr_pix, wr_col, output wr_ready);
endinterface
`default_nettype wire

// File: rtl/sprite_linebuf_pp_bank.sv
`default_nettype none
// ============================================================================
// Module      : sprite_lb_bank
// Description : One line bank: 2**AW x DW single-port synchronous RAM with
//               one clock of read latency (read-before-write). Contents are
//               not reset.
//   clk48m   in   system clock
//   i_en     in   port enable (read, or write when i_we)
//   i_we     in   write enable
//   i_addr   in   address
//   i_wdata  in   write data
//   o_rdata  out  read data, valid the clock after an enabled access
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_lb_bank #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  wire logic          clk48m,
  input  wire logic          i_en,
  input  wire logic          i_we,
  input  wire logic [AW-1:0] i_addr,
  input  wire logic [DW-1:0] i_wdata,
  output logic      [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk48m) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end
      o_rdata <= r_mem[i_addr];
    end
  end
endmodule
`default_nettype wire

// File: rtl/sprite_linebuf_pp.sv
`default_nettype none
// ============================================================================
// Module      : sprite_linebuf_pp
// Description : Ping-pong sprite line buffer. Sprite pixels are written into
//               one bank while the other is scanned out and cleared behind
//               the beam. Optional first-writer-wins priority (read-modify-
//               write), transparent-pixel skip, flipped scan and h-offset.
//   clk48m        in   system clock
//   reset         in   synchronous, active-high
//   i_ce_pix      in   scan pixel strobe (>= 2 clk apart)
//   i_line_start  in   swap banks, load scan x from i_h_offset
//   i_flip        in   scan address = rd_x ^ all-ones
//   i_h_offset    in   scan start x
//   wr            slave write channel (sprite_linebuf_pp_if)
//   o_rd_pix      out  scanned pixel (2 clk after i_ce_pix)
//   o_rd_col      out  scanned colour
//   o_overrun     out  1-clk pulse: line_start aborted a pending write
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_linebuf_pp
  import sprite_linebuf_pp_pkg::*;
#(
  parameter int XW         = DEF_XW,
  parameter int PIXW       = DEF_PIXW,
  parameter int COLW       = DEF_COLW,
  parameter int PRIO_FIRST = 1
) (
  input  wire logic            clk48m,
  input  wire logic            reset,
  input  wire logic            i_ce_pix,
  input  wire logic            i_line_start,
  input  wire logic            i_flip,
  input  wire logic [XW-1:0]   i_h_offset,
  sprite_linebuf_pp_if.slave   wr,
  output logic      [PIXW-1:0] o_rd_pix,
  output logic      [COLW-1:0] o_rd_col,
  output logic                 o_overrun
);
  localparam int              DW           = PIXW + COLW;
  localparam logic [PIXW-1:0] c_pix_transp = PIXW'(PIX_TRANSPARENT);

  // scan side
  logic          r_rd_bank, r_rd_vld, r_rd_sel, r_clr, r_clr_bank;
  logic [XW-1:0] r_rd_x, r_clr_addr;
  // write side
  lb_wstate_t      r_state;
  logic            r_ready, r_overrun;
  logic [XW-1:0]   r_x;
  logic [PIXW-1:0] r_pix;
  logic [COLW-1:0] r_col;

  logic          w_rbank, w_wbank, w_accept, w_opaque;
  logic [XW-1:0] w_rx, w_scan_addr;
  logic          w_wp_en, w_wp_we;
  logic [XW-1:0] w_wp_addr;
  logic [DW-1:0] w_wp_data, w_wdout, w_rd_word;
  logic [DW-1:0] w_dout [2];

  // line_start takes effect in its own cycle: a coincident scan read or
  // write already sees the swapped banks and the new start x.
  assign w_rbank     = i_line_start ? ~r_rd_bank : r_rd_bank;
  assign w_wbank     = ~w_rbank;
  assign w_rx        = i_line_start ? i_h_offset : r_rd_x;
  assign w_scan_addr = w_rx ^ {XW{i_flip}};
  assign w_accept    = wr.wr_valid & r_ready;
  assign w_opaque    = (wr.wr_pix != c_pix_transp);
  assign w_wdout     = w_dout[~r_rd_bank];
  assign w_rd_word   = w_dout[r_rd_sel];

  assign wr.wr_ready = r_ready;
  assign o_overrun   = r_overrun;

  // Write-FSM port request; a line_start in W_RD/W_WR kills the access.
  always_comb begin
    w_wp_en   = 1'b0;
    w_wp_we   = 1'b0;
    w_wp_addr = r_x;
    w_wp_data = {r_col, r_pix};
    case (r_state)
      W_IDLE: begin
        if ((PRIO_FIRST == 0) && w_accept && w_opaque) begin
          w_wp_en   = 1'b1;
          w_wp_we   = 1'b1;
          w_wp_addr = wr.wr_x;
          w_wp_data = {wr.wr_col, wr.wr_pix};
        end
      end
      W_RD: w_wp_en = ~i_line_start;
      W_WR: begin
        // first writer wins: only fill a location still transparent
        if (!i_line_start && (w_wdout[PIXW-1:0] == c_pix_transp)) begin
          w_wp_en = 1'b1;
          w_wp_we = 1'b1;
        end
      end
      default: w_wp_en = 1'b0;
    endcase
    if (reset) begin
      w_wp_en = 1'b0;
    end
  end

  // Per-bank port mux: scan read > clear-behind > write FSM. The clear only
  // collides with the write FSM when line_start follows a ce_pix by one clk.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic          w_en, w_we, w_scan_hit, w_clr_hit;
    logic [XW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    assign w_scan_hit = i_ce_pix & ~reset & (w_rbank == 1'(b));
    assign w_clr_hit  = r_clr & ~reset & (r_clr_bank == 1'(b));

    always_comb begin
      w_en    = 1'b0;
      w_we    = 1'b0;
      w_addr  = w_wp_addr;
      w_wdata = w_wp_data;
      if (w_scan_hit) begin
        w_en   = 1'b1;
        w_addr = w_scan_addr;
      end else if (w_clr_hit) begin
        w_en    = 1'b1;
        w_we    = 1'b1;
        w_addr  = r_clr_addr;
        w_wdata = '0;
      end else if (w_wp_en && (w_wbank == 1'(b))) begin
        w_en = 1'b1;
        w_we = w_wp_we;
      end
    end

    sprite_lb_bank #(.AW(XW), .DW(DW)) u_bank (
      .clk48m  (clk48m),
      .i_en    (w_en),
      .i_we    (w_we),
      .i_addr  (w_addr),
      .i_wdata (w_wdata),
      .o_rdata (w_dout[b])
    );
  end

  // Scan side: bank swap, scan counter, clear-behind and output registers.
  always_ff @(posedge clk48m) begin
    if (reset) begin
      r_rd_bank  <= 1'b0;
      r_rd_x     <= '0;
      r_clr      <= 1'b0;
      r_clr_bank <= 1'b0;
      r_clr_addr <= '0;
      r_rd_vld   <= 1'b0;
      r_rd_sel   <= 1'b0;
      o_rd_pix   <= '0;
      o_rd_col   <= '0;
    end else begin
      r_rd_bank  <= w_rbank;
      r_rd_x     <= i_ce_pix ? (w_rx + XW'(1)) : w_rx;
      r_clr      <= i_ce_pix;
      r_clr_bank <= w_rbank;
      r_clr_addr <= w_scan_addr;
      r_rd_vld   <= i_ce_pix;
      r_rd_sel   <= w_rbank;
      if (r_rd_vld) begin
        o_rd_pix <= w_rd_word[PIXW-1:0];
        o_rd_col <= w_rd_word[DW-1:PIXW];
      end
    end
  end

  // Write FSM (W_RD/W_WR only used for first-writer-wins priority).
  always_ff @(posedge clk48m) begin
    if (reset) begin
      r_state   <= W_IDLE;
      r_ready   <= 1'b0;
      r_overrun <= 1'b0;
      r_x       <= '0;
      r_pix     <= '0;
      r_col     <= '0;
    end else begin
      r_overrun <= 1'b0;
      case (r_state)
        W_IDLE: begin
          r_ready <= 1'b1;
          if ((PRIO_FIRST != 0) && w_accept && w_opaque) begin
            r_state <= W_RD;
            r_ready <= 1'b0;
            r_x     <= wr.wr_x;
            r_pix   <= wr.wr_pix;
            r_col   <= wr.wr_col;
          end
        end
        W_RD: begin
          if (i_line_start) begin
            r_state   <= W_IDLE;
            r_ready   <= 1'b1;
            r_overrun <= 1'b1;
          end else begin
            r_state <= W_WR;
          end
        end
        W_WR: begin
          r_state   <= W_IDLE;
          r_ready   <= 1'b1;
          r_overrun <= i_line_start;
        end
        default: begin
          r_state <= W_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_sprite_linebuf_pp.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_linebuf_pp
// Description : Directed bench for sprite_linebuf_pp. Two DUTs share the scan
//               controls: u_dut0 (last writer wins) and u_dut1 (first writer
//               wins), each with its own write channel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_linebuf_pp;
  logic clk48m = 1'b0;
  logic reset, ce, ls, flip;
  logic [7:0] hoff;
  logic [1:0]      wv;
  logic [1:0][7:0] wx;
  logic [1:0][2:0] wp;
  logic [1:0][4:0] wc;
  logic [1:0]      rdy;
  logic [1:0][2:0] rpix;
  logic [1:0][4:0] rcol;
  logic [1:0]      ovr;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk48m = ~clk48m;

  sprite_linebuf_pp_if #(.XW(8), .PIXW(3), .COLW(5)) wif0 ();
  sprite_linebuf_pp_if #(.XW(8), .PIXW(3), .COLW(5)) wif1 ();

  assign wif0.wr_valid = wv[0];
  assign wif0.wr_x     = wx[0];
  assign wif0.wr_pix   = wp[0];
  assign wif0.wr_col   = wc[0];
  assign wif1.wr_valid = wv[1];
  assign wif1.wr_x     = wx[1];
  assign wif1.wr_pix   = wp[1];
  assign wif1.wr_col   = wc[1];
  assign rdy = {wif1.wr_ready, wif0.wr_ready};

  sprite_linebuf_pp #(.XW(8), .PIXW(3), .COLW(5), .PRIO_FIRST(0)) u_dut0 (
    .clk48m(clk48m), .reset(reset), .i_ce_pix(ce), .i_line_start(ls),
    .i_flip(flip), .i_h_offset(hoff), .wr(wif0),
    .o_rd_pix(rpix[0]), .o_rd_col(rcol[0]), .o_overrun(ovr[0]));

  sprite_linebuf_pp #(.XW(8), .PIXW(3), .COLW(5), .PRIO_FIRST(1)) u_dut1 (
    .clk48m(clk48m), .reset(reset), .i_ce_pix(ce), .i_line_start(ls),
    .i_flip(flip), .i_h_offset(hoff), .wr(wif1),
    .o_rd_pix(rpix[1]), .o_rd_col(rcol[1]), .o_overrun(ovr[1]));

  typedef struct {
    logic [7:0] x;
    logic [2:0] pix;
    logic [4:0] col;
    logic [2:0] e0p;  // final value at x, last writer wins
    logic [4:0] e0c;
    logic [2:0] e1p;  // final value at x, first writer wins
    logic [4:0] e1c;
  } vec_t;

  vec_t       tbl [8];
  logic [2:0] e_pix [2][256];
  logic [4:0] e_col [2][256];

  task automatic tick();
    @(posedge clk48m);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_exp();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) begin
        e_pix[d][i] = '0;
        e_col[d][i] = '0;
      end
  endtask

  task automatic pulse_ls();
    ls = 1'b1;
    tick();
    ls = 1'b0;
  endtask

  task automatic flush_line();
    for (int i = 0; i < 256; i++) begin
      ce = 1'b1; tick();
      ce = 1'b0; tick();
    end
  endtask

  // Scan a full line; step i compares against e_*[d][i]. One comparison per
  // DUT per line, reporting the first mismatching step.
  task automatic scan(input string name, input bit ls_first);
    int bad [2];
    int pos [2];
    logic [7:0] got [2];
    logic [7:0] want [2];
    for (int d = 0; d < 2; d++) begin
      bad[d] = 0; pos[d] = 0; got[d] = '0; want[d] = '0;
    end
    for (int i = 0; i < 256; i++) begin
      ce = 1'b1;
      ls = ls_first && (i == 0);
      tick();
      ce = 1'b0;
      ls = 1'b0;
      tick();
      for (int d = 0; d < 2; d++) begin
        if ({rcol[d], rpix[d]} !== {e_col[d][i], e_pix[d][i]}) begin
          if (bad[d] == 0) begin
            pos[d]  = i;
            got[d]  = {rcol[d], rpix[d]};
            want[d] = {e_col[d][i], e_pix[d][i]};
          end
          bad[d]++;
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (bad[d] != 0) begin
        n_fail++;
        $display("FAIL %s dut%0d: %0d bad steps, first step %0d got col/pix %0d/%0d expected %0d/%0d",
                 name, d, bad[d], pos[d], got[d][7:3], got[d][2:0], want[d][7:3], want[d][2:0]);
      end
    end
  endtask

  task automatic wait_rdy(input int d);
    int t = 0;
    while (!rdy[d] && t < 20) begin
      tick();
      t++;
    end
    chk("wr_ready_timeout", 32'(rdy[d]), 32'd1);
  endtask

  task automatic wr_px(input int d, input logic [7:0] x, input logic [2:0] p, input logic [4:0] c);
    wv[d] = 1'b1; wx[d] = x; wp[d] = p; wc[d] = c;
    wait_rdy(d);
    tick();
    wv[d] = 1'b0;
    if (d == 1 && p != 3'd0) begin
      chk("rmw_ready_low1", 32'(rdy[1]), 32'd0);
      tick();
      chk("rmw_ready_low2", 32'(rdy[1]), 32'd0);
      tick();
      chk("rmw_ready_back", 32'(rdy[1]), 32'd1);
    end else begin
      chk("wr_ready_stays", 32'(rdy[d]), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'd10,  3'd3, 5'd5,  3'd6, 5'd1,  3'd3, 5'd5};
    tbl[1] = '{8'd10,  3'd6, 5'd1,  3'd6, 5'd1,  3'd3, 5'd5};
    tbl[2] = '{8'd20,  3'd2, 5'd7,  3'd2, 5'd7,  3'd2, 5'd7};
    tbl[3] = '{8'd20,  3'd0, 5'd3,  3'd2, 5'd7,  3'd2, 5'd7};
    tbl[4] = '{8'd30,  3'd5, 5'd3,  3'd1, 5'd1,  3'd5, 5'd3};
    tbl[5] = '{8'd30,  3'd1, 5'd1,  3'd1, 5'd1,  3'd5, 5'd3};
    tbl[6] = '{8'd255, 3'd7, 5'd31, 3'd7, 5'd31, 3'd7, 5'd31};
    tbl[7] = '{8'd101, 3'd0, 5'd4,  3'd0, 5'd0,  3'd0, 5'd0};

    reset = 1'b1; ce = 1'b0; ls = 1'b0; flip = 1'b0; hoff = '0;
    wv = '0; wx = '0; wp = '0; wc = '0;
    tick(); tick();
    chk("reset_ready", 32'(rdy), 32'd0);
    chk("reset_overrun", 32'(ovr), 32'd0);
    chk("reset_rd_pix", 32'(rpix), 32'd0);
    chk("reset_rd_col", 32'(rcol), 32'd0);
    reset = 1'b0;
    tick();
    chk("ready_after_reset", 32'(rdy), 32'd3);

    // Clear both banks via clear-behind; leaves rd_bank=0, write bank 1.
    flush_line(); pulse_ls(); flush_line(); pulse_ls();

    // Priority / transparent skip, table driven.
    for (int r = 0; r < 8; r++) begin
      wr_px(0, tbl[r].x, tbl[r].pix, tbl[r].col);
      wr_px(1, tbl[r].x, tbl[r].pix, tbl[r].col);
    end
    tick(); tick(); tick();
    pulse_ls();
    clear_exp();
    for (int r = 0; r < 8; r++) begin
      e_pix[0][tbl[r].x] = tbl[r].e0p; e_col[0][tbl[r].x] = tbl[r].e0c;
      e_pix[1][tbl[r].x] = tbl[r].e1p; e_col[1][tbl[r].x] = tbl[r].e1c;
    end
    scan("prio_scan", 1'b0);

    // Rescanning the same bank after two swaps sees only cleared pixels.
    pulse_ls(); pulse_ls();
    clear_exp();
    scan("clear_behind", 1'b0);

    // Flip + h_offset, line_start coincident with the first ce_pix.
    wr_px(0, 8'd0, 3'd4, 5'd9);
    wr_px(1, 8'd0, 3'd4, 5'd9);
    tick(); tick(); tick();
    flip = 1'b1; hoff = 8'd250;
    clear_exp();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      a = 8'(250 + i) ^ 8'hFF;
      if (a == 8'd0) begin
        e_pix[0][i] = 3'd4; e_col[0][i] = 5'd9;
        e_pix[1][i] = 3'd4; e_col[1][i] = 5'd9;
      end
    end
    chk("flip_expect_step", 32'(e_pix[1][5]), 32'd4);
    scan("flip_offset", 1'b1);
    flip = 1'b0; hoff = '0;

    // line_start one clk after an RMW accept: overrun, pixel dropped.
    wv[1] = 1'b1; wx[1] = 8'd50; wp[1] = 3'd3; wc[1] = 5'd2;
    wait_rdy(1);
    tick();
    wv[1] = 1'b0;
    ls = 1'b1; tick(); ls = 1'b0;
    chk("overrun_pulse", 32'(ovr), 32'd2);
    chk("overrun_ready", 32'(rdy[1]), 32'd1);
    tick();
    chk("overrun_one_clk", 32'(ovr), 32'd0);
    clear_exp();
    scan("overrun_bank_a", 1'b0);
    pulse_ls();
    scan("overrun_bank_b", 1'b0);

    // Write coincident with line_start lands in the new write bank.
    wv = 2'b11; wx = {8'd60, 8'd60}; wp = {3'd5, 3'd5}; wc = {5'd6, 5'd6};
    chk("ls_wr_ready", 32'(rdy), 32'd3);
    ls = 1'b1; tick(); ls = 1'b0; wv = 2'b00;
    chk("ls_wr_no_overrun", 32'(ovr), 32'd0);
    tick(); tick(); tick();
    pulse_ls();
    clear_exp();
    e_pix[0][60] = 3'd5; e_col[0][60] = 5'd6;
    e_pix[1][60] = 3'd5; e_col[1][60] = 5'd6;
    scan("ls_wr_newbank", 1'b0);

    // Reset in the middle of an RMW: pending write dropped.
    wv[1] = 1'b1; wx[1] = 8'd70; wp[1] = 3'd2; wc[1] = 5'd3;
    wait_rdy(1);
    tick();
    wv[1] = 1'b0;
    reset = 1'b1; tick();
    chk("midrst_ready_low", 32'(rdy[1]), 32'd0);
    chk("midrst_rd_pix", 32'(rpix), 32'd0);
    reset = 1'b0; tick();
    chk("midrst_ready_back", 32'(rdy), 32'd3);
    chk("midrst_overrun", 32'(ovr), 32'd0);
    pulse_ls();
    clear_exp();
    scan("midrst_dropped", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
